// File: rtl/rr_arb4_if.sv
// rtl/rr_arb4_if.sv - request/grant bundle between requesters and the rr_arb4 arbiter
interface rr_arb4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       busy;
    logic       idlen;
    logic [1:0] gid;
`ifdef RR_ARB4_TIMEOUT_EN
    logic       to_err;

    modport master (output req, output done, input gnt, input busy, input idlen, input gid, input to_err);
    modport slave  (input req, input done, output gnt, output busy, output idlen, output gid, output to_err);
`else
    modport master (output req, output done, input gnt, input busy, input idlen, input gid);
    modport slave  (input req, input done, output gnt, output busy, output idlen, output gid);
`endif
endinterface

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - 4-way round-robin arbiter with mandatory gap cycle; RR_ARB4_TIMEOUT_EN adds a hold limit
module rr_arb4 #(
    parameter int HOLD_MAX = 15
) (
    input  logic     clk,
    input  logic     rstb,
    rr_arb4_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] gnt;
    logic       busy;
    logic       idlen;
    logic [1:0] ptr;
    logic [1:0] winner;
    logic       release_now;

`ifdef RR_ARB4_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);
    logic [7:0] hold_cnt;
    logic       to_err;
    assign bus.to_err = to_err;
`endif

    // Scan from k=4 down to 1 so the lowest offset past ptr wins the last override.
    always_comb begin
        winner = ptr;
        for (int k = 4; k >= 1; k--) begin
            if (bus.req[2'(ptr + 2'(k))]) begin
                winner = 2'(ptr + 2'(k));
            end
        end
    end

    assign release_now = bus.done || !bus.req[ptr];

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            idlen <= 1'b1;
            ptr   <= 2'd3;
`ifdef RR_ARB4_TIMEOUT_EN
            hold_cnt <= 8'd0;
            to_err   <= 1'b0;
`endif
        end else begin
            idlen <= ~|bus.req;
`ifdef RR_ARB4_TIMEOUT_EN
            to_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt   <= 4'b0001 << winner;
                        busy  <= 1'b1;
                        ptr   <= winner;
                        state <= GRANT;
`ifdef RR_ARB4_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                        state <= GAP;
                    end
`ifdef RR_ARB4_TIMEOUT_EN
                    // A release on the limit edge wins over the timeout.
                    else if (hold_cnt + 8'd1 == HOLD_LIMIT) begin
                        gnt    <= 4'b0000;
                        busy   <= 1'b0;
                        to_err <= 1'b1;
                        state  <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt;
    assign bus.busy  = busy;
    assign bus.idlen = idlen;
    assign bus.gid   = ptr;

endmodule
